// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares the synchronous_fifo write port between NUM_REQ valid/ready requesters.
// Round-robin by default; define ARB_FIXED_PRIO_EN for lowest-index-wins arbitration.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = 4;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state, state_nxt;
  logic [GW-1:0]        grant_nxt, rr_ptr, ptr_nxt, winner;
  logic [CW-1:0]        beat_cnt, cnt_nxt;
  logic [2*NUM_REQ-1:0] valid_dbl;
  logic [NUM_REQ-1:0]   valid_rot;
  logic                 found, burst_end;
  logic                 sel_valid, sel_last;
  logic [DATA_WIDTH-1:0] sel_data;

  // Rotate the request vector so bit 0 is the requester at rr_ptr, then take the first set bit.
  always_comb begin
`ifdef ARB_FIXED_PRIO_EN
    valid_dbl = {{NUM_REQ{1'b0}}, req_valid};
`else
    valid_dbl = {req_valid, req_valid} >> rr_ptr;
`endif
    valid_rot = valid_dbl[NUM_REQ-1:0];
    winner    = '0;
    found     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && valid_rot[k]) begin
        found  = 1'b1;
        winner = GW'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == GW'(i)) begin
        sel_valid    = req_valid[i];
        sel_last     = req_last[i];
        sel_data     = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        req_ready[i] = busy && !fifo_full;
      end
    end
  end

  assign busy         = (state == GRANT);
  assign fifo_w_en    = busy && sel_valid && !fifo_full;
  assign fifo_data_in = fifo_w_en ? sel_data : '0;

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_id;
    cnt_nxt   = beat_cnt;
    ptr_nxt   = rr_ptr;
    burst_end = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          state_nxt = GRANT;
          grant_nxt = winner;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        // A full FIFO with valid still high is a stall: nothing moves.
        if (fifo_w_en) begin
          cnt_nxt   = beat_cnt + 1'b1;
          burst_end = sel_last || (beat_cnt == CW'(MAX_BURST - 1));
        end else begin
          burst_end = !sel_valid;
        end
        if (burst_end) begin
          state_nxt = IDLE;
`ifdef ARB_FIXED_PRIO_EN
          ptr_nxt   = '0;
`else
          ptr_nxt   = GW'((int'(grant_id) + 1) % NUM_REQ);
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant_id <= '0;
      beat_cnt <= '0;
      rr_ptr   <= '0;
    end else begin
      state    <= state_nxt;
      grant_id <= grant_nxt;
      beat_cnt <= cnt_nxt;
      rr_ptr   <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random traffic against a
// transaction-level requester/arbiter reference model. Honours ARB_FIXED_PRIO_EN.
module tb_fifo_wr_arbiter;
  localparam int NR   = 4;
  localparam int DW   = 8;
  localparam int MAXB = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_last;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              fifo_full;
  logic              fifo_w_en;
  logic [DW-1:0]     fifo_data_in;
  logic [1:0]        grant_id;
  logic              busy;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_w_en(fifo_w_en), .fifo_data_in(fifo_data_in), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Requester sources: each entry is {last, data}; a requester presents its head while enabled.
  logic [DW:0]   src_q [NR][$];
  logic [NR-1:0] en;
  logic [DW-1:0] fifo_q [$];

  // Reference model state.
  bit            m_grant;
  int            m_g, m_beats, m_ptr;
  logic          e_busy, e_wen;
  logic [DW-1:0] e_data;
  logic [NR-1:0] e_ready;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit pending();
    for (int i = 0; i < NR; i++) if (src_q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_grant = 1'b0; m_g = 0; m_beats = 0; m_ptr = 0;
  endtask

  task automatic drive_inputs();
    logic [DW:0] w;
    req_valid = '0; req_last = '0; req_data = '0;
    for (int i = 0; i < NR; i++) begin
      if (en[i] && src_q[i].size() > 0) begin
        w = src_q[i][0];
        req_valid[i] = 1'b1;
        req_last[i]  = w[DW];
        req_data[i*DW +: DW] = w[DW-1:0];
      end
    end
  endtask

  task automatic model_outputs();
    e_busy = m_grant; e_wen = 1'b0; e_data = '0; e_ready = '0;
    if (m_grant) begin
      if (!fifo_full) e_ready = NR'(1) << m_g;
      e_wen = req_valid[m_g] && !fifo_full;
      if (e_wen) e_data = req_data[m_g*DW +: DW];
    end
  endtask

  task automatic model_step();
    logic [DW:0] w;
    bit done;
    int pick;
    done = 1'b0;
    if (!m_grant) begin
      if (req_valid != '0) begin
        pick = -1;
        for (int k = 0; k < NR; k++)
          if (pick < 0 && req_valid[(m_ptr + k) % NR]) pick = (m_ptr + k) % NR;
        m_g = pick; m_beats = 0; m_grant = 1'b1;
      end
    end else begin
      if (e_wen) begin
        w = src_q[m_g].pop_front();
        m_beats++;
        done = w[DW] || (m_beats == MAXB);
      end else if (!req_valid[m_g]) begin
        done = 1'b1;
      end
      if (done) begin
        m_grant = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
        m_ptr = 0;
`else
        m_ptr = (m_g + 1) % NR;
`endif
      end
    end
  endtask

  task automatic cycle();
    drive_inputs();
    model_outputs();
    #1;
    chk("busy", busy, e_busy);
    chk("w_en", fifo_w_en, e_wen);
    chk("data", fifo_data_in, e_data);
    chk("ready", req_ready, e_ready);
    chk("grant_id", grant_id, m_g);
    if (fifo_w_en) fifo_q.push_back(fifo_data_in);
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while ((pending() || m_grant) && n < max) begin cycle(); n++; end
    chk("drain_done", (pending() || m_grant) ? 1 : 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; fifo_full = 1'b0; en = '0;
    for (int i = 0; i < NR; i++) src_q[i].delete();
    model_reset();
    drive_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    fifo_q.delete();
  endtask

  task automatic push(input int r, input int d, input bit lst);
    src_q[r].push_back({lst, DW'(d)});
  endtask

`ifdef ARB_FIXED_PRIO_EN
  int exp3 [12] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h28, 'h29, 'h30, 'h31};
`else
  int exp3 [12] = '{'h20, 'h21, 'h22, 'h23, 'h30, 'h24, 'h25, 'h26, 'h27, 'h31, 'h28, 'h29};
`endif

  initial begin
    logic [4:0] pat;
    int sz, tot_push, e;

    // Reset state
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_w_en", fifo_w_en, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_data", fifo_data_in, 0);
    chk("rst_grant_id", grant_id, 0);

    // Single requester, 3-word burst
    push(1, 'hA1, 0); push(1, 'hB2, 0); push(1, 'hC3, 1);
    en[1] = 1'b1;
    pat = '0;
    for (int c = 0; c < 5; c++) begin
      sz = fifo_q.size(); cycle(); pat = {pat[3:0], fifo_q.size() > sz};
    end
    chk("t1_wen_pattern", pat, 5'b01110);
    chk("t1_count", fifo_q.size(), 3);
    if (fifo_q.size() == 3) begin
      chk("t1_word0", fifo_q[0], 'hA1);
      chk("t1_word1", fifo_q[1], 'hB2);
      chk("t1_word2", fifo_q[2], 'hC3);
    end
    push(0, 'h01, 1); push(2, 'h02, 1); push(3, 'h03, 1);
    en = '1;
    cycle();
`ifdef ARB_FIXED_PRIO_EN
    chk("t1_next_winner", grant_id, 0);
`else
    chk("t1_next_winner", grant_id, 2);
`endif
    drain(40);

    // All requesters valid, two 1-word bursts each
    do_reset();
    for (int i = 0; i < NR; i++) for (int j = 0; j < 2; j++) push(i, i*16 + j, 1);
    en = '1;
    drain(60);
    chk("t2_count", fifo_q.size(), 8);
    for (int k = 0; k < 8 && k < fifo_q.size(); k++) begin
`ifdef ARB_FIXED_PRIO_EN
      e = (k / 2) * 16 + (k % 2);
`else
      e = (k % NR) * 16 + (k / NR);
`endif
      chk("t2_order", fifo_q[k], e);
    end

    // Long stream from req 2 split by MAX_BURST, req 3 interleaved
    do_reset();
    for (int j = 0; j < 10; j++) push(2, 'h20 + j, 0);
    push(3, 'h30, 1); push(3, 'h31, 1);
    en[2] = 1'b1; en[3] = 1'b1;
    drain(80);
    chk("t3_count", fifo_q.size(), 12);
    for (int k = 0; k < 12 && k < fifo_q.size(); k++) chk("t3_order", fifo_q[k], exp3[k]);

    // FIFO full for 5 cycles mid-burst
    do_reset();
    for (int j = 0; j < 6; j++) push(1, 'h10 + j, j == 5);
    en[1] = 1'b1;
    cycle(); cycle(); cycle();
    fifo_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk("t4_stall_gid", grant_id, 1);
      chk("t4_stall_busy", busy, 1);
    end
    chk("t4_no_write_in_stall", fifo_q.size(), 2);
    fifo_full = 1'b0;
    drain(40);
    chk("t4_count", fifo_q.size(), 6);
    for (int k = 0; k < 6 && k < fifo_q.size(); k++) chk("t4_order", fifo_q[k], 'h10 + k);

    // Reset during the second beat
    do_reset();
    for (int j = 0; j < 4; j++) push(0, 'h40 + j, j == 3);
    en[0] = 1'b1;
    cycle(); cycle();
    drive_inputs();
    #1;
    chk("t5_wen_before", fifo_w_en, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_wen_async", fifo_w_en, 0);
    chk("t5_ready_async", req_ready, 0);
    chk("t5_busy_async", busy, 0);
    for (int i = 0; i < NR; i++) src_q[i].delete();
    en = '0;
    model_reset();
    drive_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("t5_busy_after", busy, 0);
    chk("t5_gid_after", grant_id, 0);
    @(posedge clk); #1;

    // Granted requester withdraws after one beat
    do_reset();
    push(1, 'h10, 0); push(1, 'h11, 0); push(1, 'h12, 0);
    push(3, 'h30, 1);
    en[1] = 1'b1; en[3] = 1'b1;
    cycle(); cycle();
    en[1] = 1'b0;
    cycle();
    chk("t6_idle_after_drop", busy, 0);
    cycle();
    chk("t6_next_grant", grant_id, 3);
    chk("t6_next_busy", busy, 1);
    cycle();
    chk("t6_count", fifo_q.size(), 2);
    if (fifo_q.size() == 2) begin
      chk("t6_word0", fifo_q[0], 'h10);
      chk("t6_word1", fifo_q[1], 'h30);
    end
    src_q[1].delete();
    drain(20);

    // Random traffic
    do_reset();
    tot_push = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (src_q[i].size() < 6 && $urandom_range(0, 2) == 0) begin
          push(i, $urandom_range(0, 255), $urandom_range(0, 3) == 0);
          tot_push++;
        end
        en[i] = ($urandom_range(0, 7) != 0);
      end
      fifo_full = ($urandom_range(0, 4) == 0);
      cycle();
    end
    en = '1;
    fifo_full = 1'b0;
    drain(400);
    chk("rand_word_count", fifo_q.size(), tot_push);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
